// File: rtl/i_encoder.sv
// rtl/i_encoder.sv - packs a write request into six 16-bit flits and streams them with valid/ready
// Optional build macro: ENCODER_PARITY_EN (tail carries even parity over body1..body4)
module i_encoder #(
  parameter logic [7:0] DEST_ID = 8'h00,
  parameter logic [7:0] SRC_ID  = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  input  logic [31:0] i_wdata,
  input  logic [13:0] i_address,
  input  logic        i_read_write_enable,
  input  logic        i_flit_ready,
  output logic        o_ready,
  output logic [15:0] o_flit,
  output logic        o_flit_valid,
  output logic        o_flit_last,
  output logic [15:0] o_head_flit,
  output logic [15:0] o_body_flit_1,
  output logic [15:0] o_body_flit_2,
  output logic [15:0] o_body_flit_3,
  output logic [15:0] o_body_flit_4,
  output logic [15:0] o_tail_flit,
  output logic        o_en,
  output logic        o_done
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [2:0]  nxt_idx;
  logic [31:0] wdata_q;
  logic [13:0] addr_q;
  logic        rw_q;
  logic [15:0] body1, body2, body3, body4;
  logic        parity;
  logic [15:0] nxt_flit;

  always_comb begin
    body1 = {addr_q, rw_q, 1'b0};
    body2 = {wdata_q[31:17], 1'b0};
    body3 = {wdata_q[16:2], 1'b0};
    body4 = {wdata_q[1:0], 14'b0};
`ifdef ENCODER_PARITY_EN
    parity = ^{body1, body2, body3, body4};
`else
    parity = 1'b0;
`endif
  end

  // Next flit comes from the registered parallel copy so the stream matches it exactly.
  always_comb begin
    nxt_idx = idx + 3'd1;
    case (nxt_idx)
      3'd1:    nxt_flit = o_body_flit_1;
      3'd2:    nxt_flit = o_body_flit_2;
      3'd3:    nxt_flit = o_body_flit_3;
      3'd4:    nxt_flit = o_body_flit_4;
      default: nxt_flit = o_tail_flit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= 3'd0;
      wdata_q       <= 32'd0;
      addr_q        <= 14'd0;
      rw_q          <= 1'b0;
      o_ready       <= 1'b1;
      o_flit        <= 16'd0;
      o_flit_valid  <= 1'b0;
      o_flit_last   <= 1'b0;
      o_head_flit   <= 16'd0;
      o_body_flit_1 <= 16'd0;
      o_body_flit_2 <= 16'd0;
      o_body_flit_3 <= 16'd0;
      o_body_flit_4 <= 16'd0;
      o_tail_flit   <= 16'd0;
      o_en          <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_en   <= 1'b0;
      o_done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_en) begin
            wdata_q <= i_wdata;
            addr_q  <= i_address;
            rw_q    <= i_read_write_enable;
            o_ready <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          o_head_flit   <= {DEST_ID, SRC_ID};
          o_body_flit_1 <= body1;
          o_body_flit_2 <= body2;
          o_body_flit_3 <= body3;
          o_body_flit_4 <= body4;
          o_tail_flit   <= {2'b11, 13'b0, parity};
          o_flit        <= {DEST_ID, SRC_ID};
          o_flit_valid  <= 1'b1;
          o_flit_last   <= 1'b0;
          o_en          <= 1'b1;
          idx           <= 3'd0;
          state         <= SEND;
        end
        SEND: begin
          if (o_flit_valid && i_flit_ready) begin
            if (idx == 3'd5) begin
              o_flit_valid <= 1'b0;
              o_flit_last  <= 1'b0;
              o_done       <= 1'b1;
              state        <= DONE;
            end else begin
              idx         <= nxt_idx;
              o_flit      <= nxt_flit;
              o_flit_last <= (nxt_idx == 3'd5);
            end
          end
        end
        default: begin
          o_ready <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i_encoder.sv
// tb/tb_i_encoder.sv - scoreboard bench for i_encoder with randomized packets and directed corner cases
module tb_i_encoder;

  localparam logic [7:0] DEST = 8'h05;
  localparam logic [7:0] SRC  = 8'h0A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_en = 1'b0;
  logic [31:0] i_wdata = 32'd0;
  logic [13:0] i_address = 14'd0;
  logic        i_read_write_enable = 1'b0;
  logic        i_flit_ready = 1'b1;
  logic        o_ready, o_flit_valid, o_flit_last, o_en, o_done;
  logic [15:0] o_flit, o_head_flit, o_body_flit_1, o_body_flit_2, o_body_flit_3, o_body_flit_4, o_tail_flit;

  i_encoder #(.DEST_ID(DEST), .SRC_ID(SRC)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_wdata(i_wdata), .i_address(i_address),
    .i_read_write_enable(i_read_write_enable), .i_flit_ready(i_flit_ready),
    .o_ready(o_ready), .o_flit(o_flit), .o_flit_valid(o_flit_valid), .o_flit_last(o_flit_last),
    .o_head_flit(o_head_flit), .o_body_flit_1(o_body_flit_1), .o_body_flit_2(o_body_flit_2),
    .o_body_flit_3(o_body_flit_3), .o_body_flit_4(o_body_flit_4), .o_tail_flit(o_tail_flit),
    .o_en(o_en), .o_done(o_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int acc_cnt = 0;
  int done_pending = 0;
  int rdy_mode = 0;
  logic [15:0] flit_q[$];
  logic        last_q[$];
  logic [95:0] par_q[$];
  logic [95:0] last_pkt = 96'd0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference packet built from field arithmetic: element 5 is head, element 0 is tail.
  function automatic logic [5:0][15:0] model(input logic [13:0] a, input logic rw, input logic [31:0] w);
    logic [5:0][15:0] f;
    int unsigned b1, b2, b3, b4, p;
    b1 = (int'(a) * 4 + int'(rw) * 2) % 65536;
    b2 = (w / 32'd131072) * 2;
    b3 = ((w / 4) % 32768) * 2;
    b4 = (w % 4) * 16384;
    p = 0;
`ifdef ENCODER_PARITY_EN
    p = ($countones(b1) + $countones(b2) + $countones(b3) + $countones(b4)) % 2;
`endif
    f[5] = {DEST, SRC};
    f[4] = 16'(b1);
    f[3] = 16'(b2);
    f[2] = 16'(b3);
    f[1] = 16'(b4);
    f[0] = 16'(32'hC000 + p);
    return f;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_flit_valid && i_flit_ready) begin
        acc_cnt++;
        if (flit_q.size() == 0) check("unexpected_flit", {80'd0, o_flit}, 96'hDEAD);
        else begin
          check("flit", {79'd0, o_flit_last, o_flit}, {79'd0, last_q.pop_front(), flit_q.pop_front()});
        end
      end
      if (o_en) begin
        if (par_q.size() == 0) check("unexpected_o_en", 96'd1, 96'd0);
        else check("parallel", {o_head_flit, o_body_flit_1, o_body_flit_2, o_body_flit_3, o_body_flit_4, o_tail_flit},
                   par_q.pop_front());
      end
      if (o_done) begin
        check("done_expected", {95'd0, done_pending > 0 && flit_q.size() == 0}, 96'd1);
        if (done_pending > 0) done_pending--;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) i_flit_ready = 1'b1;
      else if (rdy_mode == 1) i_flit_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [13:0] a, input logic rw, input logic [31:0] w);
    logic [5:0][15:0] f;
    int n;
    n = 0;
    @(negedge clk);
    while (!o_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) check("wait_ready_timeout", 96'd0, 96'd1);
    f = model(a, rw, w);
    for (int i = 5; i >= 0; i--) begin
      flit_q.push_back(f[i]);
      last_q.push_back(i == 0);
    end
    par_q.push_back({f[5], f[4], f[3], f[2], f[1], f[0]});
    last_pkt = {f[5], f[4], f[3], f[2], f[1], f[0]};
    done_pending++;
    i_address = a; i_read_write_enable = rw; i_wdata = w; i_en = 1'b1;
    @(posedge clk);
    #1;
    i_en = 1'b0;
    i_address = 14'($urandom); i_read_write_enable = 1'($urandom); i_wdata = $urandom;
  endtask

  task automatic wait_done(input bit pulse);
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      i_en = 1'b0;
      if (done_pending == 0 && flit_q.size() == 0) break;
      if (o_flit_valid) begin
        if (o_ready) check("ready_low_in_send", 96'd1, 96'd0);
        if (pulse && $urandom_range(0, 3) == 0) i_en = 1'b1;
      end
      n++;
    end
    i_en = 1'b0;
    if (n >= 300) check("packet_timeout", 96'd0, 96'd1);
  endtask

  initial begin
    int n;
    logic [5:0][15:0] f;
    #12;
    check("reset_values", {84'd0, o_ready, o_flit_valid, o_flit_last, o_en, o_done, o_flit == 16'd0,
          ({o_head_flit, o_body_flit_1, o_body_flit_2, o_body_flit_3, o_body_flit_4, o_tail_flit} == 96'd0), 5'd0},
          {84'd0, 1'b1, 4'b0000, 1'b1, 1'b1, 5'd0});
    @(negedge clk);
    rst_n = 1'b1;

    // Reference packet with latency measurement.
    f = model(14'h1234, 1'b1, 32'hDEADBEEF);
    check("model_ref", {f[5], f[4], f[3], f[2], f[1], f[0]}, 96'h050A_48D2_DEAC_DF76_C000_C000 | {95'd0, f[0][0]});
    send(14'h1234, 1'b1, 32'hDEADBEEF);
    @(negedge clk);
    check("load_cycle_idle_stream", {94'd0, o_flit_valid, o_en}, 96'd0);
    @(negedge clk);
    check("first_send_cycle", {78'd0, o_flit_valid, o_en, o_flit}, {78'd0, 2'b11, 16'h050A});
    n = 2;
    while (!o_done && n < 30) begin @(negedge clk); n++; end
    check("done_latency", 96'(n), 96'd8);
    wait_done(0);
    @(negedge clk);
    check("idle_after_done", {94'd0, o_ready, o_done}, 96'd2);

    send(14'h0000, 1'b0, 32'h00000001);
    wait_done(0);
    f = model(14'h0000, 1'b0, 32'h00000001);
`ifdef ENCODER_PARITY_EN
    check("tail_parity", {80'd0, o_tail_flit}, 96'hC001);
`else
    check("tail_no_parity", {80'd0, o_tail_flit}, 96'hC000);
`endif
    check("body4_lsb", {80'd0, o_body_flit_4}, 96'h4000);

    // Stall on body2 for three cycles.
    rdy_mode = 2;
    i_flit_ready = 1'b1;
    send(14'h1234, 1'b1, 32'hDEADBEEF);
    n = 0;
    while (!(o_flit_valid && o_flit == 16'hDEAC) && n < 30) begin @(posedge clk); #1; n++; end
    i_flit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold", {79'd0, o_flit_valid, o_flit}, {79'd0, 1'b1, 16'hDEAC});
    end
    @(posedge clk); #1;
    i_flit_ready = 1'b1;
    @(negedge clk);
    check("stall_release", {79'd0, o_flit_valid, o_flit}, {79'd0, 1'b1, 16'hDEAC});
    wait_done(0);
    rdy_mode = 0;

    // i_en pulses during SEND must be ignored.
    send(14'h2AAA, 1'b1, 32'h12345678);
    wait_done(1);
    repeat (4) @(negedge clk);
    check("no_spurious_packet", {94'd0, o_flit_valid, o_ready}, 96'd1);

    // Reset after three flits accepted.
    send(14'h0F0F, 1'b0, 32'hCAFEF00D);
    n = acc_cnt;
    begin
      int t;
      t = 0;
      while (acc_cnt - n < 3 && t < 30) begin @(posedge clk); #1; t++; end
    end
    rst_n = 1'b0;
    #1;
    check("abort_state", {93'd0, o_flit_valid, o_ready, o_done}, 96'd2);
    flit_q.delete(); last_q.delete(); par_q.delete(); done_pending = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_resume", {94'd0, o_flit_valid, o_ready}, 96'd1);
    send(14'h0F0F, 1'b0, 32'hCAFEF00D);
    wait_done(0);

    // Random traffic with random backpressure.
    rdy_mode = 1;
    for (int k = 0; k < 30; k++) begin
      send(14'($urandom), 1'($urandom), $urandom);
      wait_done(1);
    end
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    check("parallel_hold", {o_head_flit, o_body_flit_1, o_body_flit_2, o_body_flit_3, o_body_flit_4, o_tail_flit}, last_pkt);
    check("queues_drained", 96'(flit_q.size() + par_q.size() + done_pending), 96'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i_encoder.md
I_ENCODER -- requirements
Module: i_encoder

Interface
REQ-001 Parameter DEST_ID, default 8'h00, destination node ID placed in head flit [15:8].
REQ-002 Parameter SRC_ID, default 8'h00, source node ID placed in head flit [7:0].
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_en  input  1  packet request, sampled only in IDLE.
REQ-006 i_wdata  input  32  write data to encode.
REQ-007 i_address  input  14  target address to encode.
REQ-008 i_read_write_enable  input  1  read/write flag to encode.
REQ-009 i_flit_ready  input  1  downstream accepts o_flit this cycle.
REQ-010 o_ready  output  1  high only in IDLE; request can be taken.
REQ-011 o_flit  output  16  serial flit stream.
REQ-012 o_flit_valid  output  1  o_flit holds a valid flit.
REQ-013 o_flit_last  output  1  current flit is the tail.
REQ-014 o_head_flit, o_body_flit_1..4, o_tail_flit  output  16 each  registered parallel copy of the packet.
REQ-015 o_en  output  1  one-cycle strobe: parallel flits valid.
REQ-016 o_done  output  1  one-cycle strobe: tail accepted.

Function
REQ-017 FSM states IDLE, LOAD, SEND, DONE; encoding is free.
REQ-018 IDLE: on i_en=1 at a rising edge, capture i_wdata, i_address, i_read_write_enable; go to LOAD.
REQ-019 LOAD (one cycle): build the flits and register the parallel outputs; go to SEND with flit index 0.
REQ-020 Head = {DEST_ID, SRC_ID}; body1 = {address[13:0], rw, 1'b0}.
REQ-021 Body2 = {wdata[31:17], 1'b0}; body3 = {wdata[16:2], 1'b0}; body4 = {wdata[1:0], 14'b0}.
REQ-022 Tail = {2'b11, 13'b0, p}; p defined in REQ-034/035.
REQ-023 o_en SHALL pulse high exactly in the first SEND cycle.
REQ-024 SEND: o_flit_valid=1; o_flit = flit[index], order head, body1..4, tail.
REQ-025 Index advances only when o_flit_valid and i_flit_ready are both high at an edge.
REQ-026 o_flit and o_flit_last SHALL stay stable while valid and not ready.
REQ-027 o_flit_last=1 only while index=5.
REQ-028 Tail accepted -> DONE; o_done=1 for that one cycle; then IDLE.
REQ-029 Latency: i_en sampled at edge k -> first o_flit_valid in cycle after edge k+1. With ready tied high, o_done is in the cycle after edge k+7.
REQ-030 i_en outside IDLE is ignored and not queued; captured fields are not altered mid-packet.
REQ-031 Parallel outputs hold the last packet until the next LOAD.

Reset
REQ-032 rst_n low at any time, including mid-packet, SHALL force IDLE immediately and abort the packet with no o_done.
REQ-033 Reset values: o_flit=0, o_flit_valid=0, o_flit_last=0, o_en=0, o_done=0, all parallel flits=0, o_ready=1.

Configuration
REQ-034 With ENCODER_PARITY_EN defined: p = XOR of all 64 bits of body1..body4 (even parity).
REQ-035 Without ENCODER_PARITY_EN: p = 0; tail is always 16'hC000.

Verification
REQ-036 DEST_ID=8'h05, SRC_ID=8'h0A; addr 14'h1234, rw=1, wdata 32'hDEADBEEF; ready high.
  Required flits: 050A, 48D2, DEAC, DF76, C000, C000.
  Required strobes: o_flit_last only on the sixth flit; o_done one cycle after tail.
REQ-037 addr 0, rw 0, wdata 32'h00000001 -> body4=16'h4000; tail 16'hC001 with macro, 16'hC000 without.
REQ-038 Same packet as REQ-036, i_flit_ready low 3 cycles while body2 is presented.
  Required: o_flit holds DEAC and valid stays 1 for 4 cycles; no flit skipped or repeated.
REQ-039 i_en pulsed during SEND -> ignored; exactly 6 flits; o_ready=1 only after DONE.
REQ-040 rst_n low after 3 flits accepted -> o_flit_valid=0 immediately; no o_done; o_ready=1.
  Next request after release: full 6-flit packet starting with the head flit.
